// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// One iteration per clock, flushable, with MTHI/MTLO writes while idle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   p_q, p_nx, prod_fix;
  logic [WIDTH:0]       msum, shifted, diff;
  logic [WIDTH-1:0]     a_mag, b_mag, quo, rem, res_hi, res_lo;
  logic                 is_signed, last_fire;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && rs[WIDTH-1]) ? -rs : rs;
  assign b_mag     = (is_signed && rt[WIDTH-1]) ? -rt : rt;

  // p_q: {accumulator, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    msum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{p_q[0]}} & b_q};
    shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (!is_div_q)
      p_nx = {msum, p_q[WIDTH-1:1]};
    else if (!diff[WIDTH])
      p_nx = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    else
      p_nx = {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
  end

  // Sign correction applied to the value the final iteration produces
  always_comb begin
    prod_fix = neg_res_q ? -p_nx : p_nx;
    quo      = neg_res_q ? -p_nx[WIDTH-1:0] : p_nx[WIDTH-1:0];
    rem      = neg_rem_q ? -p_nx[2*WIDTH-1:WIDTH] : p_nx[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (b_q == '0) begin
      // remainder restores to the original rs; quotient forced to all ones
      res_hi = rem;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_fire = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        if (flush) state_d = IDLE;
        else if (cnt_q == LAST) begin
          state_d   = DONE;
          last_fire = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_q       <= '0;
      p_q       <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        cnt_q     <= '0;
        is_div_q  <= op[1];
        neg_res_q <= is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
        neg_rem_q <= is_signed & rs[WIDTH-1];
        b_q       <= op[1] ? b_mag : a_mag;
        p_q       <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
      end
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      p_q   <= p_nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end else if (last_fire) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: spec vectors, random ops vs. an
// arithmetic reference model, and flush/reset/write corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs, rt, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural result straight from integer arithmetic: {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin p = ua * ub; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin q = sa / sb; r = sa % sb; end
        else begin q = ua / ub; r = ua % ub; end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Launch in cycle 0, verify busy 1..32, done only in 33, results from 33, idle in 34
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    logic ok;
    ok = 1'b1;
    step();
    op = o; rs = a; rt = b; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
      step();
    end
    @(negedge clk);
    if (!(done === 1'b1 && busy === 1'b0)) ok = 1'b0;
    chk({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, el});
    step();
    @(negedge clk);
    if (!(done === 1'b0 && busy === 1'b0)) ok = 1'b0;
    chk({name, " timing"}, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [63:0] e;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic        seen;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};

    resetn = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; rs = '0; rt = '0; wdata = '0;
    #12;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].exp_hi, vecs[i].exp_lo);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      e = ref_model(ro, ra, rb);
      run_op($sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, e[63:32], e[31:0]);
    end

    // MTHI/MTLO preset, then flush in cycle 10 with ignored start/hi_we in CALC
    step(); hi_we = 1'b1; wdata = 32'h1234;
    step(); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    step(); lo_we = 1'b0;
    @(negedge clk);
    chk("mthi", {32'd0, hi}, 64'h1234);
    chk("mtlo", {32'd0, lo}, 64'h5678);
    step(); op = 2'b00; rs = 32'd3; rt = 32'd4; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) begin start = 1'b1; op = 2'b01; hi_we = 1'b1; wdata = 32'hDEAD; end
      if (c == 6) begin start = 1'b0; hi_we = 1'b0; end
      step();
    end
    flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("flush busy c11", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("flush no done/restart", {63'd0, seen}, 64'd0);
    chk("flush hi kept", {32'd0, hi}, 64'h1234);
    chk("flush lo kept", {32'd0, lo}, 64'h5678);

    // Flush coinciding with the final CALC edge
    step(); op = 2'b01; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 1; c <= 31; c++) step();
    flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("late flush done", {62'd0, done, busy}, 64'd0);
    chk("late flush hi", {32'd0, hi}, 64'h1234);
    chk("late flush lo", {32'd0, lo}, 64'h5678);

    // Write and start at the same edge: write lands, result overwrites later
    step(); op = 2'b01; rs = 32'd2; rt = 32'd3; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA;
    step(); start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk("wr+start hi c1", {32'd0, hi}, 64'hAAAA);
    chk("wr+start lo c1", {32'd0, lo}, 64'hAAAA);
    for (int c = 1; c <= 32; c++) step();
    @(negedge clk);
    chk("wr+start done c33", {62'd0, done, busy}, 64'd2);
    chk("wr+start result", {hi, lo}, 64'd6);

    // Asynchronous reset mid-cycle 15 of a DIVU
    step(); op = 2'b11; rs = 32'd1000; rt = 32'd3; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 1; c <= 14; c++) step();
    #2 resetn = 1'b0;
    #1;
    chk("async rst busy/done", {62'd0, busy, done}, 64'd0);
    chk("async rst hi/lo", {hi, lo}, 64'd0);
    step(); step();
    @(negedge clk);
    resetn = 1'b1;
    run_op("post-reset multu", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
